// File: rtl/iuq_ic_miss_arb.sv
// iuq_ic_miss_arb: round-robin L2 request arbiter and in-flight miss tracker
// for the icache reload path. It issues one pending miss per cycle under
// credit flow control and compares each new miss address with the
// addresses already in flight.
//
// Ports:
//   sm_req/sm_ci/sm_addr/sm_cancel  per-SM pending request, CI flag,
//                                   line address and iu2 flush cancel
//   sm_release                      tag reload done, free tracker entry
//   new_miss_addr / addr_match      iu2 miss address vs in-flight tags
//   sm_gnt                          one-hot grant pulse back to the SMs
//   l2_req_*                        registered L2 request (tag/addr/ci)
//   l2_credit_ret / credit_err      credit return, sticky credit error
//
// Build option: define IUQ_MISS_ARB_ADDR_MATCH_EN to keep the tracker
// address storage and comparator. Otherwise addr_match is tied to 0.
module iuq_ic_miss_arb #(
    parameter int NUM_SM  = 4,
    parameter int CREDITS = 2,
    parameter int AW      = 42
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_SM-1:0]    sm_req,
    input  logic [NUM_SM-1:0]    sm_ci,
    input  logic [NUM_SM*AW-1:0] sm_addr,
    input  logic [NUM_SM-1:0]    sm_cancel,
    input  logic [NUM_SM-1:0]    sm_release,
    input  logic [AW-1:0]        new_miss_addr,
    output logic                 addr_match,
    output logic [NUM_SM-1:0]    sm_gnt,
    output logic                 l2_req_val,
    output logic [2:0]           l2_req_tag,
    output logic [AW-1:0]        l2_req_addr,
    output logic                 l2_req_ci,
    input  logic                 l2_credit_ret,
    output logic                 credit_err
);

    localparam logic [2:0] CRED_MAX = 3'(CREDITS);

    logic [2:0]        cred;
    logic [2:0]        rr;
    logic [NUM_SM-1:0] trk_v;
    logic [NUM_SM-1:0] elig;
    logic [7:0]        elig_x;
    logic              win;
    logic [2:0]        g;
    logic [NUM_SM-1:0] gnt_oh;
    logic [AW-1:0]     sel_addr;
    logic              sel_ci;

    // A tag already in flight is never eligible, so an early re-request
    // by an SM is simply ignored until its release.
    assign elig   = sm_req & ~sm_cancel & ~trk_v;
    assign elig_x = 8'(elig);

    always_comb begin
        win = 1'b0;
        g   = 3'd0;
        for (int k = 0; k < NUM_SM; k++) begin
            if (!win && elig_x[3'((int'(rr) + k) % NUM_SM)]) begin
                win = 1'b1;
                g   = 3'((int'(rr) + k) % NUM_SM);
            end
        end
        if (cred == 3'd0) begin
            win = 1'b0;
        end
    end

    always_comb begin
        gnt_oh   = '0;
        sel_addr = '0;
        sel_ci   = 1'b0;
        for (int i = 0; i < NUM_SM; i++) begin
            if (g == 3'(i)) begin
                gnt_oh[i] = win;
                sel_addr  = sm_addr[i*AW +: AW];
                sel_ci    = sm_ci[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sm_gnt      <= '0;
            l2_req_val  <= 1'b0;
            l2_req_tag  <= 3'd0;
            l2_req_addr <= '0;
            l2_req_ci   <= 1'b0;
            rr          <= 3'd0;
            trk_v       <= '0;
        end else begin
            sm_gnt     <= gnt_oh;
            l2_req_val <= win;
            // Grant set beats a same-cycle release of that tag.
            trk_v      <= (trk_v & ~sm_release) | gnt_oh;
            if (win) begin
                l2_req_tag  <= g;
                l2_req_addr <= sel_addr;
                l2_req_ci   <= sel_ci;
                rr          <= 3'((int'(g) + 1) % NUM_SM);
            end
        end
    end

    // Issue with a same-cycle return nets to no change. A return with the
    // pool already full is dropped and flagged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cred       <= CRED_MAX;
            credit_err <= 1'b0;
        end else begin
            if (win && !l2_credit_ret) begin
                cred <= cred - 3'd1;
            end else if (!win && l2_credit_ret) begin
                if (cred >= CRED_MAX) begin
                    credit_err <= 1'b1;
                end else begin
                    cred <= cred + 3'd1;
                end
            end
        end
    end

`ifdef IUQ_MISS_ARB_ADDR_MATCH_EN
    logic [AW-1:0] trk_addr [NUM_SM];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_SM; i++) begin
                trk_addr[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_SM; i++) begin
                if (gnt_oh[i]) begin
                    trk_addr[i] <= sel_addr;
                end
            end
        end
    end

    // The entry being granted this cycle is not yet in trk_addr, so its
    // address is bypassed straight from the winning SM.
    always_comb begin
        addr_match = win && (sel_addr == new_miss_addr);
        for (int i = 0; i < NUM_SM; i++) begin
            if (trk_v[i] && (trk_addr[i] == new_miss_addr)) begin
                addr_match = 1'b1;
            end
        end
    end
`else
    logic unused_miss_addr;
    assign unused_miss_addr = ^new_miss_addr;
    assign addr_match       = 1'b0;
`endif

endmodule

// File: tb/tb_iuq_ic_miss_arb.sv
// tb_iuq_ic_miss_arb: self-checking bench for iuq_ic_miss_arb.
// L2 requests are scored against a queue of expected grants.
module tb_iuq_ic_miss_arb;

    localparam int NUM_SM  = 4;
    localparam int CREDITS = 2;
    localparam int AW      = 42;

`ifdef IUQ_MISS_ARB_ADDR_MATCH_EN
    localparam logic EXP_M = 1'b1;
`else
    localparam logic EXP_M = 1'b0;
`endif

    typedef struct {
        logic [2:0]    tag;
        logic [AW-1:0] addr;
        logic          ci;
    } exp_t;

    logic                 clk;
    logic                 rst_n;
    logic [NUM_SM-1:0]    sm_req;
    logic [NUM_SM-1:0]    sm_ci;
    logic [NUM_SM*AW-1:0] sm_addr;
    logic [NUM_SM-1:0]    sm_cancel;
    logic [NUM_SM-1:0]    sm_release;
    logic [AW-1:0]        new_miss_addr;
    logic                 addr_match;
    logic [NUM_SM-1:0]    sm_gnt;
    logic                 l2_req_val;
    logic [2:0]           l2_req_tag;
    logic [AW-1:0]        l2_req_addr;
    logic                 l2_req_ci;
    logic                 l2_credit_ret;
    logic                 credit_err;

    exp_t sb[$];
    exp_t e;
    int   n_chk  = 0;
    int   n_pass = 0;

    iuq_ic_miss_arb #(
        .NUM_SM (NUM_SM),
        .CREDITS(CREDITS),
        .AW     (AW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sm_req       (sm_req),
        .sm_ci        (sm_ci),
        .sm_addr      (sm_addr),
        .sm_cancel    (sm_cancel),
        .sm_release   (sm_release),
        .new_miss_addr(new_miss_addr),
        .addr_match   (addr_match),
        .sm_gnt       (sm_gnt),
        .l2_req_val   (l2_req_val),
        .l2_req_tag   (l2_req_tag),
        .l2_req_addr  (l2_req_addr),
        .l2_req_ci    (l2_req_ci),
        .l2_credit_ret(l2_credit_ret),
        .credit_err   (credit_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [AW-1:0] addr_of(input int i);
        return 42'h0AB_0000_0000 + 42'(i * 273);
    endfunction

    task automatic push(input int t);
        exp_t x;
        x.tag  = 3'(t);
        x.addr = sm_addr[t*AW +: AW];
        x.ci   = sm_ci[t];
        sb.push_back(x);
    endtask

    // Scoreboard: every L2 request must match the oldest expected grant.
    always @(negedge clk) begin
        if (rst_n && l2_req_val) begin
            n_chk++;
            if (sb.size() == 0) begin
                $display("FAIL l2_unexpected got tag=%0d want none",
                         l2_req_tag);
            end else begin
                e = sb.pop_front();
                if (l2_req_tag !== e.tag || l2_req_addr !== e.addr ||
                    l2_req_ci !== e.ci ||
                    sm_gnt !== (4'b0001 << e.tag)) begin
                    $display("FAIL l2_req got tag=%0d addr=%h ci=%b gnt=%b want tag=%0d addr=%h ci=%b",
                             l2_req_tag, l2_req_addr, l2_req_ci, sm_gnt,
                             e.tag, e.addr, e.ci);
                end else begin
                    n_pass++;
                end
            end
        end
    end

    task automatic test_reset;
        rst_n         = 1'b0;
        sm_req        = '0;
        sm_ci         = 4'b0101;
        sm_cancel     = '0;
        sm_release    = '0;
        l2_credit_ret = 1'b0;
        new_miss_addr = '0;
        for (int i = 0; i < NUM_SM; i++) begin
            sm_addr[i*AW +: AW] = addr_of(i);
        end
        @(negedge clk);
        #1;
        n_chk++;
        if (sm_gnt !== 4'b0 || l2_req_val !== 1'b0 ||
            l2_req_tag !== 3'd0 || l2_req_addr !== '0 ||
            l2_req_ci !== 1'b0 || credit_err !== 1'b0 ||
            addr_match !== 1'b0) begin
            $display("FAIL reset got gnt=%b val=%b tag=%0d addr=%h ci=%b err=%b m=%b want all 0",
                     sm_gnt, l2_req_val, l2_req_tag, l2_req_addr,
                     l2_req_ci, credit_err, addr_match);
        end else begin
            n_pass++;
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_credit_stall;
        @(negedge clk);
        sm_req = 4'b1111;
        push(0);
        push(1);
        @(negedge clk);
        n_chk++;
        if (sm_gnt !== 4'b0001)
            $display("FAIL cs_g0 got=%b want=0001", sm_gnt);
        else n_pass++;
        @(negedge clk);
        n_chk++;
        if (sm_gnt !== 4'b0010)
            $display("FAIL cs_g1 got=%b want=0010", sm_gnt);
        else n_pass++;
        @(negedge clk);
        n_chk++;
        if (sm_gnt !== 4'b0000)
            $display("FAIL cs_stall got=%b want=0000", sm_gnt);
        else n_pass++;
        l2_credit_ret = 1'b1;
        push(2);
        @(negedge clk);
        l2_credit_ret = 1'b0;
        n_chk++;
        if (sm_gnt !== 4'b0000)
            $display("FAIL cs_ret_lat got=%b want=0000", sm_gnt);
        else n_pass++;
        @(negedge clk);
        n_chk++;
        if (sm_gnt !== 4'b0100)
            $display("FAIL cs_g2 got=%b want=0100", sm_gnt);
        else n_pass++;
        @(negedge clk);
        n_chk++;
        if (sm_gnt !== 4'b0000)
            $display("FAIL cs_stall2 got=%b want=0000", sm_gnt);
        else n_pass++;
        sm_req        = '0;
        sm_release    = 4'b0111;
        l2_credit_ret = 1'b1;
        @(negedge clk);
        sm_release = '0;
        @(negedge clk);
        l2_credit_ret = 1'b0;
    endtask

    task automatic test_round_robin;
        @(negedge clk);
        sm_req = 4'b1000;
        push(3);
        @(negedge clk);
        n_chk++;
        if (sm_gnt !== 4'b1000)
            $display("FAIL rr_g3 got=%b want=1000", sm_gnt);
        else n_pass++;
        sm_req     = '0;
        sm_release = 4'b1000;
        @(negedge clk);
        sm_release    = '0;
        sm_req        = 4'b1010;
        l2_credit_ret = 1'b1;
        push(1);
        @(negedge clk);
        n_chk++;
        if (sm_gnt !== 4'b0010)
            $display("FAIL rr_g1 got=%b want=0010", sm_gnt);
        else n_pass++;
        l2_credit_ret = 1'b0;
        push(3);
        @(negedge clk);
        n_chk++;
        if (sm_gnt !== 4'b1000)
            $display("FAIL rr_g3_after_rr2 got=%b want=1000", sm_gnt);
        else n_pass++;
        @(negedge clk);
        n_chk++;
        if (sm_gnt !== 4'b0000)
            $display("FAIL rr_idle got=%b want=0000", sm_gnt);
        else n_pass++;
        sm_req        = '0;
        sm_release    = 4'b1010;
        l2_credit_ret = 1'b1;
        @(negedge clk);
        sm_release = '0;
        @(negedge clk);
        l2_credit_ret = 1'b0;
    endtask

    task automatic test_cancel_collision;
        @(negedge clk);
        sm_req    = 4'b0011;
        sm_cancel = 4'b0001;
        push(1);
        @(negedge clk);
        n_chk++;
        if (sm_gnt !== 4'b0010)
            $display("FAIL cancel_g1 got=%b want=0010", sm_gnt);
        else n_pass++;
        sm_req    = 4'b0001;
        sm_cancel = '0;
        push(0);
        @(negedge clk);
        n_chk++;
        if (sm_gnt !== 4'b0001)
            $display("FAIL cancel_t0_free got=%b want=0001", sm_gnt);
        else n_pass++;
        sm_req        = '0;
        sm_release    = 4'b0011;
        l2_credit_ret = 1'b1;
        @(negedge clk);
        sm_release = '0;
        @(negedge clk);
        l2_credit_ret = 1'b0;
    endtask

    task automatic test_addr_match;
        @(negedge clk);
        sm_addr[2*AW +: AW] = 42'h123_4567_8900;
        new_miss_addr       = 42'h123_4567_8900;
        sm_req              = 4'b0100;
        push(2);
        #1;
        n_chk++;
        if (addr_match !== EXP_M)
            $display("FAIL am_bypass got=%b want=%b", addr_match, EXP_M);
        else n_pass++;
        @(negedge clk);
        sm_req = '0;
        n_chk++;
        if (sm_gnt !== 4'b0100)
            $display("FAIL am_g2 got=%b want=0100", sm_gnt);
        else n_pass++;
        n_chk++;
        if (addr_match !== EXP_M)
            $display("FAIL am_tracked got=%b want=%b", addr_match, EXP_M);
        else n_pass++;
        new_miss_addr = 42'h123_4567_8940;
        #1;
        n_chk++;
        if (addr_match !== 1'b0)
            $display("FAIL am_miss got=%b want=0", addr_match);
        else n_pass++;
        new_miss_addr = 42'h123_4567_8900;
        sm_release    = 4'b0100;
        @(negedge clk);
        sm_release    = '0;
        l2_credit_ret = 1'b1;
        n_chk++;
        if (addr_match !== 1'b0)
            $display("FAIL am_released got=%b want=0", addr_match);
        else n_pass++;
        @(negedge clk);
        l2_credit_ret       = 1'b0;
        sm_addr[2*AW +: AW] = addr_of(2);
        new_miss_addr       = '0;
    endtask

    task automatic test_credit_err;
        @(negedge clk);
        n_chk++;
        if (credit_err !== 1'b0)
            $display("FAIL cerr_pre got=%b want=0", credit_err);
        else n_pass++;
        l2_credit_ret = 1'b1;
        @(negedge clk);
        l2_credit_ret = 1'b0;
        n_chk++;
        if (credit_err !== 1'b1)
            $display("FAIL cerr_set got=%b want=1", credit_err);
        else n_pass++;
        sm_req = 4'b1111;
        push(3);
        push(0);
        @(negedge clk);
        n_chk++;
        if (sm_gnt !== 4'b1000)
            $display("FAIL cerr_g3 got=%b want=1000", sm_gnt);
        else n_pass++;
        @(negedge clk);
        n_chk++;
        if (sm_gnt !== 4'b0001)
            $display("FAIL cerr_g0 got=%b want=0001", sm_gnt);
        else n_pass++;
        @(negedge clk);
        n_chk++;
        if (sm_gnt !== 4'b0000)
            $display("FAIL cerr_hold got=%b want=0000", sm_gnt);
        else n_pass++;
        n_chk++;
        if (credit_err !== 1'b1)
            $display("FAIL cerr_sticky got=%b want=1", credit_err);
        else n_pass++;
        sm_req        = '0;
        sm_release    = 4'b1001;
        l2_credit_ret = 1'b1;
        @(negedge clk);
        sm_release = '0;
        @(negedge clk);
        l2_credit_ret = 1'b0;
    endtask

    task automatic test_reset_inflight;
        @(negedge clk);
        sm_req = 4'b0011;
        push(1);
        push(0);
        @(negedge clk);
        n_chk++;
        if (sm_gnt !== 4'b0010)
            $display("FAIL ri_g1 got=%b want=0010", sm_gnt);
        else n_pass++;
        @(negedge clk);
        n_chk++;
        if (sm_gnt !== 4'b0001)
            $display("FAIL ri_g0 got=%b want=0001", sm_gnt);
        else n_pass++;
        #1;
        sm_req = '0;
        rst_n  = 1'b0;
        #1;
        n_chk++;
        if (sm_gnt !== 4'b0 || l2_req_val !== 1'b0 ||
            l2_req_tag !== 3'd0 || l2_req_addr !== '0 ||
            l2_req_ci !== 1'b0 || credit_err !== 1'b0 ||
            addr_match !== 1'b0) begin
            $display("FAIL ri_async got gnt=%b val=%b tag=%0d addr=%h ci=%b err=%b m=%b want all 0",
                     sm_gnt, l2_req_val, l2_req_tag, l2_req_addr,
                     l2_req_ci, credit_err, addr_match);
        end else begin
            n_pass++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        sm_req = 4'b1111;
        push(0);
        push(1);
        @(negedge clk);
        n_chk++;
        if (sm_gnt !== 4'b0001)
            $display("FAIL ri_post_g0 got=%b want=0001", sm_gnt);
        else n_pass++;
        @(negedge clk);
        n_chk++;
        if (sm_gnt !== 4'b0010)
            $display("FAIL ri_post_g1 got=%b want=0010", sm_gnt);
        else n_pass++;
        @(negedge clk);
        n_chk++;
        if (sm_gnt !== 4'b0000)
            $display("FAIL ri_post_stall got=%b want=0000", sm_gnt);
        else n_pass++;
        sm_req = '0;
        @(negedge clk);
        @(negedge clk);
        n_chk++;
        if (sb.size() != 0)
            $display("FAIL sb_drain got=%0d left want=0", sb.size());
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_credit_stall();
        test_round_robin();
        test_cancel_collision();
        test_addr_match();
        test_credit_err();
        test_reset_inflight();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

endmodule
